ahb_dma_csr: RTL and testbench
==============================

# ahb_dma_csr

Parametrised multi-channel AHB-Lite slave register file for the DMA subsystem. Holds per-channel source address, destination address and length, and runs a per-channel start/busy/done state machine. Collects per-channel completion into a sticky interrupt status. Rejects illegal accesses with a two-cycle AHB ERROR response. Sits between the AHB interconnect and NUM_CH DMA AXI engines.

## Interface
- NUM_CH, 4, number of DMA channels (1..8)
- LEN_W, 14, transfer length width per channel (1..32)
- hclk  in  1  AHB clock; sole clock
- hreset  in  1  reset, asynchronous, active-high
- hsel  in  1  slave select
- hready_in  in  1  bus ready; an address phase is accepted when hsel & hready_in & htrans[1]
- hwrite  in  1  1 = write
- htrans  in  2  IDLE/BUSY (htrans[1]=0) are ignored; NONSEQ/SEQ are transfers
- haddr  in  32  byte address; only haddr[11:0] decoded, word aligned
- hwdata  in  32  write data, data phase
- hrdata  out  32  read data, data phase
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- dma_start  out  NUM_CH  one-cycle start pulse per channel
- dma_done  in  NUM_CH  one-cycle completion pulse per channel
- dma_cfg_saddr  out  NUM_CH*32  channel c at [32c+31:32c]
- dma_cfg_daddr  out  NUM_CH*32  same packing
- dma_cfg_number  out  NUM_CH*LEN_W  same packing
- irq  out  1  OR over (int_stat & int_en)

## Operation
- Register map, offset:
  - Channel c at 0x10*c: +0x0 SADDR, +0x4 DADDR, +0x8 LEN (bits LEN_W-1:0, upper bits read 0), +0xC CTRL.
  - CTRL: bit0 START, write-1 only, reads busy; bit1 INT_EN, RW.
  - 0x100 STATUS: RO, bit c = channel c busy.
  - 0x104 INT_STAT: W1C, bit c set by dma_done[c].
  - Everything else is unmapped.
- Channel FSM, states IDLE, LAUNCH, BUSY:
  - IDLE→LAUNCH on an accepted write to CTRL with hwdata[0]=1.
  - LAUNCH lasts one cycle and drives dma_start[c]=1, then →BUSY.
  - BUSY→IDLE on dma_done[c]; that same edge sets INT_STAT[c].
  - dma_done[c] in IDLE or LAUNCH is ignored.
- Writes to SADDR, DADDR or LEN of a channel not in IDLE, and CTRL.START=1 while not in IDLE:
  - ERROR response; register not modified.
  - INT_EN-only writes (bit0=0) are always legal.
- Unmapped offset, read or write: ERROR response; write discarded; hrdata=0.
- Writes to STATUS: ERROR.
- Simultaneous dma_done[c] and W1C of INT_STAT[c]: set wins, bit stays 1.
- dma_cfg_* are continuous register outputs and are stable while a channel is BUSY.

## Timing
- Address phase registered: sel, write, offset.
- Legality is evaluated at address phase against the current FSM state.
- OKAY write: register updated on the clock edge ending the data phase (hready_in high in the data phase).
- OKAY read: zero wait states. hrdata is combinational from the registered offset, valid throughout the data phase.
- ERROR response, two cycles:
  - cycle 1: hreadyout=0, hresp=1
  - cycle 2: hreadyout=1, hresp=1
  - then idle: hreadyout=1, hresp=0.
- An address phase presented during ERROR cycle 2 is accepted normally.
- START write accepted in data phase at edge N: LAUNCH in cycle N+1, dma_start high for exactly that cycle, BUSY from N+2.
- STATUS reads 1 from the cycle after the write edge.
- irq is a registered-status OR: high the cycle after the INT_STAT set edge, low the cycle after the clearing edge.
- Reset values:
  - all registers 0, all FSMs IDLE
  - dma_start=0, irq=0, hrdata=0, hreadyout=1, hresp=0.
- Reset asserted mid-transfer or mid-ERROR aborts immediately. No dma_start pulse is generated on reset exit.

## Structure
- Package ahb_dma_pkg holds:
  - offset constants (CH_STRIDE=0x10, SADDR/DADDR/LEN/CTRL offsets, STATUS=0x100, INT_STAT=0x104)
  - CTRL bit indices
  - channel state enum {IDLE, LAUNCH, BUSY}
  - AHB htrans/hresp encodings
- Sub-module ahb_dma_ch holds one channel's SADDR/DADDR/LEN/INT_EN, its FSM and its busy flag. It is instantiated NUM_CH times in a generate loop.
- The top level owns address-phase capture, decode, the ERROR sequencer, read mux, INT_STAT and irq.

## Test plan
- Reset, then read 0x0–0x104 → all 0, OKAY, hreadyout=1.
- Write ch1 SADDR=0x1000_0000, DADDR=0x2000_0000, LEN=0x3FFF, read back → exact values. dma_cfg_number[27:14]=0x3FFF.
- Write ch2 CTRL=0x3 → dma_start[2] one cycle, 2 edges after the data phase. STATUS=0x4. Write ch2 SADDR → ERROR two cycles, value unchanged.
- Pulse dma_done[2] → STATUS=0, INT_STAT=0x4, irq=1. Same-cycle dma_done[0] with W1C 0x1 → INT_STAT bit0 remains 1.
- Read 0x0F0 and write 0x100 → ERROR (hreadyout 0 then 1, hresp 1,1). A back-to-back legal read follows with OKAY.
- Assert hreset while ch0 is BUSY → STATUS=0, irq=0, dma_start stays 0 after release.

Source files
------------

// File: rtl/ahb_dma_pkg.sv
// Shared constants, encodings and types for the DMA AHB-Lite CSR block.
package ahb_dma_pkg;

    localparam logic [11:0] CH_STRIDE    = 12'h010;
    localparam logic [11:0] OFF_SADDR    = 12'h000;
    localparam logic [11:0] OFF_DADDR    = 12'h004;
    localparam logic [11:0] OFF_LEN      = 12'h008;
    localparam logic [11:0] OFF_CTRL     = 12'h00C;
    localparam logic [11:0] OFF_STATUS   = 12'h100;
    localparam logic [11:0] OFF_INT_STAT = 12'h104;

    localparam int CTRL_START  = 0;
    localparam int CTRL_INT_EN = 1;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_LAUNCH = 2'd1,
        CH_BUSY   = 2'd2
    } ch_state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Registered address-phase attributes carried into the data phase.
    typedef struct packed {
        logic        vld;
        logic        write;
        logic [11:0] off;
        logic        err;        // illegal regardless of write data
        logic        ctrl_busy;  // CTRL write to a non-idle channel; illegal only if START=1
    } dphase_t;

endpackage

// File: rtl/ahb_dma_ch.sv
// One DMA channel: SADDR/DADDR/LEN/INT_EN registers plus IDLE/LAUNCH/BUSY sequencer.
// Latency: register writes land on the strobe edge; dma_start is high the cycle after a START write.
// Backpressure: none; config writes are dropped unless the channel is IDLE.
module ahb_dma_ch
    import ahb_dma_pkg::*;
#(
    parameter int LEN_W = 14
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             wr_saddr,
    input  logic             wr_daddr,
    input  logic             wr_len,
    input  logic             wr_ctrl,
    input  logic [31:0]      wdata,
    input  logic             dma_done,
    output logic             dma_start,
    output logic [31:0]      saddr,
    output logic [31:0]      daddr,
    output logic [LEN_W-1:0] len,
    output logic             int_en,
    output logic             busy,
    output logic             done_evt
);

    ch_state_e state_q, state_d;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= CH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dma_start = 1'b0;
        case (state_q)
            CH_IDLE:   if (wr_ctrl && wdata[CTRL_START]) state_d = CH_LAUNCH;
            CH_LAUNCH: begin
                dma_start = 1'b1;
                state_d   = CH_BUSY;
            end
            CH_BUSY:   if (dma_done) state_d = CH_IDLE;
            default:   state_d = CH_IDLE;
        endcase
    end

    assign busy     = (state_q != CH_IDLE);
    assign done_evt = (state_q == CH_BUSY) && dma_done;

    // The IDLE guard keeps dma_cfg_* frozen even if a write slipped past the address-phase check.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            saddr  <= '0;
            daddr  <= '0;
            len    <= '0;
            int_en <= 1'b0;
        end else begin
            if (state_q == CH_IDLE) begin
                if (wr_saddr) saddr <= wdata;
                if (wr_daddr) daddr <= wdata;
                if (wr_len)   len   <= wdata[LEN_W-1:0];
            end
            if (wr_ctrl) int_en <= wdata[CTRL_INT_EN];
        end
    end

endmodule

// File: rtl/ahb_dma_csr.sv
// AHB-Lite CSR slave for NUM_CH DMA channels with sticky interrupt status and ERROR sequencer.
// Latency: zero-wait OKAY reads/writes; write lands on the edge ending the data phase.
// Backpressure: hreadyout drops only in the first cycle of the two-cycle ERROR response.
module ahb_dma_csr
    import ahb_dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 14
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic                      hready_in,
    input  logic                      hwrite,
    input  logic [1:0]                htrans,
    input  logic [31:0]               haddr,
    input  logic [31:0]               hwdata,
    output logic [31:0]               hrdata,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [NUM_CH-1:0]         dma_start,
    input  logic [NUM_CH-1:0]         dma_done,
    output logic [NUM_CH*32-1:0]      dma_cfg_saddr,
    output logic [NUM_CH*32-1:0]      dma_cfg_daddr,
    output logic [NUM_CH*LEN_W-1:0]   dma_cfg_number,
    output logic                      irq
);

    logic              acc;
    logic [11:0]       a_off;
    logic              a_ch_hit, a_ch_idle, a_is_ctrl, a_err, a_ctrl_busy;
    dphase_t           dp;
    logic              err1, err2_q, dp_ok, wr_en, w1c;
    logic [NUM_CH-1:0] wr_saddr, wr_daddr, wr_len, wr_ctrl;
    logic [NUM_CH-1:0] ch_busy, ch_int_en, ch_done, int_stat;
    logic [31:0]       rd;
    logic              unused_haddr;

    assign unused_haddr = ^haddr[31:12];

    assign acc = hsel && hready_in && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    always_comb begin
        a_off     = haddr[11:0];
        a_ch_hit  = (a_off[11:8] == 4'h0) && ({28'd0, a_off[7:4]} < 32'(NUM_CH));
        a_is_ctrl = (a_off[3:0] == OFF_CTRL[3:0]);
        a_ch_idle = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (a_off[6:4] == 3'(c)) a_ch_idle = ~ch_busy[c];
        end
        a_err = (a_off[1:0] != 2'b00)
              || !(a_ch_hit || (a_off == OFF_STATUS) || (a_off == OFF_INT_STAT))
              || (hwrite && (a_off == OFF_STATUS))
              || (hwrite && a_ch_hit && !a_is_ctrl && !a_ch_idle);
        a_ctrl_busy = hwrite && a_ch_hit && a_is_ctrl && !a_ch_idle;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp     <= '0;
            err2_q <= 1'b0;
        end else begin
            if (hready_in) begin
                dp.vld       <= acc;
                dp.write     <= hwrite;
                dp.off       <= a_off;
                dp.err       <= a_err;
                dp.ctrl_busy <= a_ctrl_busy;
            end
            err2_q <= err1;
        end
    end

    // START legality needs hwdata, so the first ERROR cycle is resolved in the data phase.
    assign err1      = dp.vld && !err2_q && (dp.err || (dp.ctrl_busy && hwdata[CTRL_START]));
    assign dp_ok     = dp.vld && !err2_q && !err1;
    assign wr_en     = dp_ok && dp.write && hready_in;
    assign w1c       = wr_en && (dp.off == OFF_INT_STAT);
    assign hreadyout = !err1;
    assign hresp     = (err1 || err2_q) ? HRESP_ERROR : HRESP_OKAY;

    always_comb begin
        wr_saddr = '0;
        wr_daddr = '0;
        wr_len   = '0;
        wr_ctrl  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (dp.off[11:8] == 4'h0) && (dp.off[7:4] == 4'(c))) begin
                case (dp.off[3:0])
                    OFF_SADDR[3:0]: wr_saddr[c] = 1'b1;
                    OFF_DADDR[3:0]: wr_daddr[c] = 1'b1;
                    OFF_LEN[3:0]:   wr_len[c]   = 1'b1;
                    OFF_CTRL[3:0]:  wr_ctrl[c]  = 1'b1;
                    default:        ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ahb_dma_ch #(.LEN_W(LEN_W)) u_ch (
            .hclk      (hclk),
            .hreset    (hreset),
            .wr_saddr  (wr_saddr[c]),
            .wr_daddr  (wr_daddr[c]),
            .wr_len    (wr_len[c]),
            .wr_ctrl   (wr_ctrl[c]),
            .wdata     (hwdata),
            .dma_done  (dma_done[c]),
            .dma_start (dma_start[c]),
            .saddr     (dma_cfg_saddr[32*c +: 32]),
            .daddr     (dma_cfg_daddr[32*c +: 32]),
            .len       (dma_cfg_number[LEN_W*c +: LEN_W]),
            .int_en    (ch_int_en[c]),
            .busy      (ch_busy[c]),
            .done_evt  (ch_done[c])
        );
    end

    // Completion set is OR-ed after the clear so a same-edge done wins.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            int_stat <= '0;
        end else begin
            int_stat <= (int_stat & ~(w1c ? hwdata[NUM_CH-1:0] : '0)) | ch_done;
        end
    end

    assign irq = |(int_stat & ch_int_en);

    always_comb begin
        rd = '0;
        if (dp_ok && !dp.write) begin
            if (dp.off == OFF_STATUS) begin
                rd[NUM_CH-1:0] = ch_busy;
            end else if (dp.off == OFF_INT_STAT) begin
                rd[NUM_CH-1:0] = int_stat;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (dp.off[7:4] == 4'(c)) begin
                        case (dp.off[3:0])
                            OFF_SADDR[3:0]: rd = dma_cfg_saddr[32*c +: 32];
                            OFF_DADDR[3:0]: rd = dma_cfg_daddr[32*c +: 32];
                            OFF_LEN[3:0]:   rd[LEN_W-1:0] = dma_cfg_number[LEN_W*c +: LEN_W];
                            OFF_CTRL[3:0]: begin
                                rd[CTRL_START]  = ch_busy[c];
                                rd[CTRL_INT_EN] = ch_int_en[c];
                            end
                            default:        ;
                        endcase
                    end
                end
            end
        end
    end

    assign hrdata = rd;

endmodule

// File: tb/tb_ahb_dma_csr.sv
// Directed self-checking bench for ahb_dma_csr (NUM_CH=4, LEN_W=14).
module tb_ahb_dma_csr;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 14;

    logic                    hclk = 1'b0;
    logic                    hreset;
    logic                    hsel;
    logic                    hready_in;
    logic                    hwrite;
    logic [1:0]              htrans;
    logic [31:0]             haddr;
    logic [31:0]             hwdata;
    logic [31:0]             hrdata;
    logic                    hreadyout;
    logic                    hresp;
    logic [NUM_CH-1:0]       dma_start;
    logic [NUM_CH-1:0]       dma_done;
    logic [NUM_CH*32-1:0]    dma_cfg_saddr;
    logic [NUM_CH*32-1:0]    dma_cfg_daddr;
    logic [NUM_CH*LEN_W-1:0] dma_cfg_number;
    logic                    irq;

    int vecs     = 0;
    int miscmp   = 0;

    logic [31:0] rd;
    logic        r1, p1, r2, p2;

    assign hready_in = hreadyout;

    always #5 hclk = ~hclk;

    ahb_dma_csr #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
        .hclk           (hclk),
        .hreset         (hreset),
        .hsel           (hsel),
        .hready_in      (hready_in),
        .hwrite         (hwrite),
        .htrans         (htrans),
        .haddr          (haddr),
        .hwdata         (hwdata),
        .hrdata         (hrdata),
        .hreadyout      (hreadyout),
        .hresp          (hresp),
        .dma_start      (dma_start),
        .dma_done       (dma_done),
        .dma_cfg_saddr  (dma_cfg_saddr),
        .dma_cfg_daddr  (dma_cfg_daddr),
        .dma_cfg_number (dma_cfg_number),
        .irq            (irq)
    );

    // Single transfer: address phase, then data phase; records both ERROR cycles if present.
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic rdy1, output logic resp1,
                       output logic rdy2, output logic resp2);
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = wdata;
        @(negedge hclk);
        rdy1 = hreadyout; resp1 = hresp; rdata = hrdata;
        rdy2 = 1'b1; resp2 = 1'b0;
        if (!rdy1) begin
            @(negedge hclk);
            rdy2 = hreadyout; resp2 = hresp;
        end
    endtask

    task automatic pulse_done(input logic [NUM_CH-1:0] mask);
        @(posedge hclk); #1;
        dma_done = mask;
        @(posedge hclk); #1;
        dma_done = '0;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hwdata = '0; dma_done = '0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        vecs++;
        if ({hreadyout, hresp, irq, dma_start, hrdata} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0}) begin
            miscmp++;
            $display("FAIL reset_outputs: got rdy=%b resp=%b irq=%b start=%h rdata=%h, want 1 0 0 0 0",
                     hreadyout, hresp, irq, dma_start, hrdata);
        end
        @(posedge hclk); #1;
        hreset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            a = (i < 16) ? 32'(i * 4) : 32'h100 + 32'((i - 16) * 4);
            bus(1'b0, a, 32'h0, rd, r1, p1, r2, p2);
            vecs++;
            if ({r1, p1, rd} !== {1'b1, 1'b0, 32'h0}) begin
                miscmp++;
                $display("FAIL reset_read @%h: got rdy=%b resp=%b data=%h, want 1 0 00000000", a, r1, p1, rd);
            end
        end
    endtask

    task automatic test_cfg();
        bus(1'b1, 32'h10, 32'h1000_0000, rd, r1, p1, r2, p2);
        bus(1'b1, 32'h14, 32'h2000_0000, rd, r1, p1, r2, p2);
        bus(1'b1, 32'h18, 32'hFFFF_FFFF, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1} !== 2'b10) begin
            miscmp++; $display("FAIL cfg_write_resp: got rdy=%b resp=%b, want 1 0", r1, p1);
        end
        bus(1'b0, 32'h10, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h1000_0000) begin
            miscmp++; $display("FAIL ch1_saddr: got %h want 10000000", rd);
        end
        bus(1'b0, 32'h14, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h2000_0000) begin
            miscmp++; $display("FAIL ch1_daddr: got %h want 20000000", rd);
        end
        bus(1'b0, 32'h18, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h0000_3FFF) begin
            miscmp++; $display("FAIL ch1_len: got %h want 00003fff", rd);
        end
        vecs++;
        if ({dma_cfg_saddr[63:32], dma_cfg_daddr[63:32], dma_cfg_number[27:14]}
                !== {32'h1000_0000, 32'h2000_0000, 14'h3FFF}) begin
            miscmp++;
            $display("FAIL cfg_ports: got %h %h %h want 10000000 20000000 3fff",
                     dma_cfg_saddr[63:32], dma_cfg_daddr[63:32], dma_cfg_number[27:14]);
        end
    endtask

    task automatic test_start();
        bus(1'b1, 32'h2C, 32'h3, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, dma_start} !== {1'b1, 1'b0, 4'h0}) begin
            miscmp++; $display("FAIL start_dphase: got rdy=%b resp=%b start=%h want 1 0 0", r1, p1, dma_start);
        end
        @(negedge hclk);
        vecs++;
        if (dma_start !== 4'h4) begin
            miscmp++; $display("FAIL start_pulse: got %h want 4", dma_start);
        end
        @(negedge hclk);
        vecs++;
        if (dma_start !== 4'h0) begin
            miscmp++; $display("FAIL start_pulse_end: got %h want 0", dma_start);
        end
        bus(1'b0, 32'h100, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h4) begin
            miscmp++; $display("FAIL status_busy: got %h want 00000004", rd);
        end
        bus(1'b0, 32'h2C, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h3) begin
            miscmp++; $display("FAIL ch2_ctrl: got %h want 00000003", rd);
        end
        bus(1'b1, 32'h20, 32'hDEAD_BEEF, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, r2, p2} !== 4'b0111) begin
            miscmp++; $display("FAIL busy_saddr_err: got %b want 0111", {r1, p1, r2, p2});
        end
        bus(1'b0, 32'h20, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, rd, dma_cfg_saddr[95:64]} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
            miscmp++; $display("FAIL busy_saddr_kept: got rd=%h port=%h want 0 0", rd, dma_cfg_saddr[95:64]);
        end
        bus(1'b1, 32'h2C, 32'h1, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, r2, p2} !== 4'b0111) begin
            miscmp++; $display("FAIL busy_start_err: got %b want 0111", {r1, p1, r2, p2});
        end
        bus(1'b1, 32'h2C, 32'h2, rd, r1, p1, r2, p2);
        @(negedge hclk);
        vecs++;
        if ({r1, p1, dma_start} !== {1'b1, 1'b0, 4'h0}) begin
            miscmp++; $display("FAIL busy_inten_ok: got rdy=%b resp=%b start=%h want 1 0 0", r1, p1, dma_start);
        end
    endtask

    task automatic test_done_irq();
        pulse_done(4'hC);
        @(negedge hclk);
        vecs++;
        if (irq !== 1'b1) begin
            miscmp++; $display("FAIL irq_set: got %b want 1", irq);
        end
        bus(1'b0, 32'h100, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h0) begin
            miscmp++; $display("FAIL status_idle: got %h want 0", rd);
        end
        bus(1'b0, 32'h104, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h4) begin
            miscmp++; $display("FAIL int_stat_done: got %h want 00000004", rd);
        end
        // ch0 busy, then W1C of bit0 on the same edge as its done pulse.
        bus(1'b1, 32'h0C, 32'h1, rd, r1, p1, r2, p2);
        repeat (3) @(posedge hclk);
        #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h104;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
        hwdata = 32'h1; dma_done = 4'h1;
        @(posedge hclk); #1;
        dma_done = '0;
        bus(1'b0, 32'h104, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h5) begin
            miscmp++; $display("FAIL set_wins_w1c: got %h want 00000005", rd);
        end
        bus(1'b1, 32'h104, 32'h5, rd, r1, p1, r2, p2);
        bus(1'b0, 32'h104, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if ({rd, irq} !== {32'h0, 1'b0}) begin
            miscmp++; $display("FAIL w1c_clear: got stat=%h irq=%b want 0 0", rd, irq);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h0F0;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        @(negedge hclk);
        vecs++;
        if ({hreadyout, hresp, hrdata} !== {1'b0, 1'b1, 32'h0}) begin
            miscmp++; $display("FAIL err_cycle1: got rdy=%b resp=%b data=%h want 0 1 0", hreadyout, hresp, hrdata);
        end
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h010;
        @(negedge hclk);
        vecs++;
        if ({hreadyout, hresp} !== 2'b11) begin
            miscmp++; $display("FAIL err_cycle2: got rdy=%b resp=%b want 1 1", hreadyout, hresp);
        end
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; haddr = '0;
        @(negedge hclk);
        vecs++;
        if ({hreadyout, hresp, hrdata} !== {1'b1, 1'b0, 32'h1000_0000}) begin
            miscmp++; $display("FAIL b2b_read: got rdy=%b resp=%b data=%h want 1 0 10000000", hreadyout, hresp, hrdata);
        end
        bus(1'b1, 32'h100, 32'hF, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, r2, p2} !== 4'b0111) begin
            miscmp++; $display("FAIL status_write_err: got %b want 0111", {r1, p1, r2, p2});
        end
        bus(1'b0, 32'h012, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if ({r1, p1, r2, p2} !== 4'b0111) begin
            miscmp++; $display("FAIL unaligned_err: got %b want 0111", {r1, p1, r2, p2});
        end
        bus(1'b1, 32'h040, 32'h1, rd, r1, p1, r2, p2);
        @(negedge hclk);
        vecs++;
        if ({r1, p1, r2, p2, dma_start} !== {4'b0111, 4'h0}) begin
            miscmp++; $display("FAIL nonexist_ch_err: got %b start=%h want 0111 0", {r1, p1, r2, p2}, dma_start);
        end
    endtask

    task automatic test_reset_busy();
        bus(1'b1, 32'h2C, 32'h3, rd, r1, p1, r2, p2);
        repeat (2) @(posedge hclk);
        pulse_done(4'h4);
        bus(1'b1, 32'h0C, 32'h3, rd, r1, p1, r2, p2);
        bus(1'b0, 32'h100, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if ({rd, irq} !== {32'h1, 1'b1}) begin
            miscmp++; $display("FAIL pre_reset: got status=%h irq=%b want 1 1", rd, irq);
        end
        @(posedge hclk); #3;
        hreset = 1'b1;
        #1;
        vecs++;
        if ({irq, dma_start, hreadyout, hresp} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
            miscmp++; $display("FAIL async_reset: got irq=%b start=%h rdy=%b resp=%b want 0 0 1 0",
                               irq, dma_start, hreadyout, hresp);
        end
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            vecs++;
            if (dma_start !== 4'h0) begin
                miscmp++; $display("FAIL no_start_after_reset cyc%0d: got %h want 0", i, dma_start);
            end
        end
        bus(1'b0, 32'h100, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h0) begin
            miscmp++; $display("FAIL status_after_reset: got %h want 0", rd);
        end
        bus(1'b0, 32'h104, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if ({rd, irq} !== {32'h0, 1'b0}) begin
            miscmp++; $display("FAIL int_after_reset: got stat=%h irq=%b want 0 0", rd, irq);
        end
        bus(1'b0, 32'h10, 32'h0, rd, r1, p1, r2, p2);
        vecs++;
        if (rd !== 32'h0) begin
            miscmp++; $display("FAIL saddr_after_reset: got %h want 0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_start();
        test_done_irq();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1);
    end

endmodule
